// File: rtl/rpg_uart_tx_pkg.sv
// Shared definitions for the reprogram-link UART transmitter.
// Contents: FSM state encoding, frame constants, default clock/baud values
// and the baud divisor helper.
package rpg_uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    localparam int DATA_BITS  = 8;
    localparam int DEF_CLK_HZ = 50000000;
    localparam int DEF_BAUD   = 115200;

    // Clock cycles per bit; integer division truncates (434 at the defaults).
    function automatic int baud_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/rpg_uart_tx_sync_fifo.sv
// Synchronous byte FIFO feeding the UART transmitter.
// Ports:
//   clk        in   system clock, rising edge
//   rstn       in   asynchronous active-low reset (pointers and level cleared)
//   push       in   write push_data when not full
//   push_data  in   WIDTH-bit write data
//   pop        in   advance read pointer when not empty
//   pop_data   out  head entry (valid while empty==0)
//   full       out  level == DEPTH (registered level, so a push while full is
//                   dropped even if a pop happens in the same cycle)
//   empty      out  level == 0
//   level      out  number of stored entries
module rpg_uart_tx_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      level_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (level_r == LVL_FULL);
    assign empty     = (level_r == {(AW+1){1'b0}});
    assign level     = level_r;
    assign pop_data  = mem_r[rd_ptr_r];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Storage array; contents need no reset because level gates every read.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers wrap naturally modulo DEPTH (power of two); level tracks occupancy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + (AW+1)'(1);
                2'b01:   level_r <= level_r - (AW+1)'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/rpg_uart_tx.sv
// UART transmitter for the reprogram serial link (RPG_TX pin).
// Bytes are queued in a FIFO and sent as 8N1 frames, LSB first, back to back.
// Ports:
//   clk_50mhz  in   system clock, rising edge
//   rstn       in   asynchronous active-low reset; aborts any frame, tx high at once
//   wr_data    in   byte to queue
//   wr_en      in   push wr_data when full==0
//   full       out  FIFO holds FIFO_DEPTH bytes
//   level      out  bytes queued (byte on the line not counted)
//   busy       out  FIFO non-empty or frame in progress
//   tx         out  serial line, idle high, driven straight from a flop
module rpg_uart_tx
    import rpg_uart_tx_pkg::*;
#(
    parameter int CLK_HZ     = DEF_CLK_HZ,
    parameter int BAUD       = DEF_BAUD,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk_50mhz,
    input  logic                          rstn,
    input  logic [7:0]                    wr_data,
    input  logic                          wr_en,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          busy,
    output logic                          tx
);
    localparam int DIV = baud_div(CLK_HZ, BAUD);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

    tx_state_t      state_r;
    tx_state_t      state_s;
    logic [CW-1:0]  cnt_r;
    logic [2:0]     bit_idx_r;
    logic [7:0]     shreg_r;
    logic           tx_r;
    logic           tx_s;
    logic           pop_s;
    logic           last_s;
    logic           fifo_empty_s;
    logic [7:0]     fifo_data_s;

    rpg_uart_tx_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_50mhz),
        .rstn      (rstn),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (pop_s),
        .pop_data  (fifo_data_s),
        .full      (full),
        .empty     (fifo_empty_s),
        .level     (level)
    );

    assign last_s = (cnt_r == CNT_LAST);
    assign busy   = (|level) || (state_r != ST_IDLE);
    assign tx     = tx_r;

    // Next-state and pop decision; STOP's last cycle chains straight into START.
    always_comb begin
        state_s = state_r;
        pop_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    state_s = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (last_s) begin
                    state_s = ST_DATA;
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (last_s && (bit_idx_r == BIT_LAST)) begin
                    state_s = ST_STOP;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_STOP: begin
                if (last_s && !fifo_empty_s) begin
                    pop_s   = 1'b1;
                    state_s = ST_START;
                end else if (last_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_STOP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Line level for the next cycle; registering it costs one cycle of latency
    // but keeps tx glitch-free and off any combinational path from wr_en.
    always_comb begin
        tx_s = 1'b1;
        if (state_r == ST_START) begin
            tx_s = 1'b0;
        end else if (state_r == ST_DATA) begin
            tx_s = shreg_r[0];
        end else begin
            tx_s = 1'b1;
        end
    end

    // FSM state, baud counter (reloads on every state/bit entry), bit index,
    // shift register and the tx flop.
    always_ff @(posedge clk_50mhz or negedge rstn) begin
        if (!rstn) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CW{1'b0}};
            bit_idx_r <= 3'd0;
            shreg_r   <= 8'h00;
            tx_r      <= 1'b1;
        end else begin
            state_r <= state_s;
            tx_r    <= tx_s;

            if ((state_r == ST_IDLE) || (state_s != state_r) || last_s) begin
                cnt_r <= {CW{1'b0}};
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end

            if (state_r != ST_DATA) begin
                bit_idx_r <= 3'd0;
            end else if (last_s) begin
                bit_idx_r <= bit_idx_r + 3'd1;
            end else begin
                bit_idx_r <= bit_idx_r;
            end

            if (pop_s) begin
                shreg_r <= fifo_data_s;
            end else if ((state_r == ST_DATA) && last_s) begin
                shreg_r <= {1'b0, shreg_r[7:1]};
            end else begin
                shreg_r <= shreg_r;
            end
        end
    end

endmodule

// File: tb/tb_rpg_uart_tx.sv
// Bench for rpg_uart_tx at CLK_HZ=80, BAUD=10 (8 clocks per bit).
// Stimulus pushes expected bytes into exp_q; an independent line-receiver
// process decodes frames on tx and compares against the queue head.
module tb_rpg_uart_tx;
    logic        clk;
    logic        rstn;
    logic [7:0]  wr_data;
    logic        wr_en;
    logic        full;
    logic [4:0]  level;
    logic        busy;
    logic        tx;

    int          cyc;
    int          n_vec;
    int          n_err;
    logic [7:0]  exp_q[$];
    int          start_q[$];

    rpg_uart_tx #(
        .CLK_HZ     (80),
        .BAUD       (10),
        .FIFO_DEPTH (16)
    ) dut (
        .clk_50mhz (clk),
        .rstn      (rstn),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .full      (full),
        .level     (level),
        .busy      (busy),
        .tx        (tx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b, input bit expect_it);
        wr_data = b;
        wr_en   = 1'b1;
        if (expect_it) exp_q.push_back(b);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_fall(input string name, output int e);
        e = -1;
        for (int i = 0; i < 300; i++) begin
            if (tx == 1'b0) begin
                e = cyc;
                break;
            end
            @(negedge clk);
        end
        if (e < 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: timeout waiting for start bit, got tx=1, expected tx=0", name);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 4000; i++) begin
            if (exp_q.size() == 0 && !busy) break;
            @(negedge clk);
        end
        check(name, int'(exp_q.size() == 0 && !busy), 1);
    endtask

    // Line receiver: samples mid-bit from the first low cycle; aborts on reset.
    initial begin
        int         t0;
        int         tgt;
        bit         ab;
        logic [9:0] smp;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rstn && tx == 1'b0) begin
                t0  = cyc;
                ab  = 1'b0;
                smp = '0;
                for (int k = 0; k < 10; k++) begin
                    tgt = t0 + 4 + 8 * k;
                    while (cyc != tgt && !ab) begin
                        @(negedge clk);
                        if (!rstn) ab = 1'b1;
                    end
                    if (!ab) smp[k] = tx;
                end
                if (!ab) begin
                    start_q.push_back(t0);
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL frame: got unexpected byte %02h, expected no frame", smp[8:1]);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame", int'({smp[9], smp[0], smp[8:1]}), int'({1'b1, 1'b0, e}));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int n;
        int bad;
        cyc     = 0;
        n_vec   = 0;
        n_err   = 0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        rstn    = 1'b1;
        #2 rstn = 1'b0;

        // 1: reset values, then a quiet line after release
        repeat (3) @(negedge clk);
        check("rst_tx", int'(tx), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_level", int'(level), 0);
        check("rst_full", int'(full), 0);
        rstn = 1'b1;
        bad  = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("idle_quiet", bad, 0);

        // 2: single 0x55, latency and end-of-frame boundary
        wr_data = 8'h55;
        wr_en   = 1'b1;
        exp_q.push_back(8'h55);
        @(negedge clk);
        n     = cyc;
        wr_en = 1'b0;
        check("lat_n0", int'(tx), 1);
        @(negedge clk);
        check("lat_n1", int'(tx), 1);
        @(negedge clk);
        check("lat_n2", int'(tx), 0);
        check("busy_frame", int'(busy), 1);
        wait_cyc(n + 80);
        check("busy_stop", int'(busy), 1);
        wait_cyc(n + 82);
        check("busy_done", int'(busy), 0);
        check("tx_done", int'(tx), 1);
        drain("drain_single");

        // 3: three bytes back to back, no gap between frames
        start_q.delete();
        push(8'hA5, 1'b1);
        push(8'h00, 1'b1);
        push(8'hFF, 1'b1);
        check("b2b_level", int'(level), 2);
        drain("drain_b2b");
        check("b2b_frames", start_q.size(), 3);
        if (start_q.size() == 3) begin
            check("b2b_gap1", start_q[1] - start_q[0], 80);
            check("b2b_gap2", start_q[2] - start_q[1], 80);
        end

        // 4: overflow while a frame occupies the line
        push(8'h5A, 1'b1);
        wait_fall("ovf_start", e);
        for (int i = 0; i < 16; i++) push(8'(i), 1'b1);
        check("ovf_full", int'(full), 1);
        check("ovf_level16", int'(level), 16);
        push(8'h10, 1'b0);
        check("ovf_drop_level", int'(level), 16);
        if (e >= 0) begin
            wait_cyc(e + 79);
            check("ovf_pop_level", int'(level), 15);
            check("ovf_pop_full", int'(full), 0);
        end
        drain("drain_ovf");

        // 5: push and pop in the same cycle at level 3
        push(8'hC1, 1'b1);
        wait_fall("pp_start", e);
        push(8'hC2, 1'b1);
        push(8'hC3, 1'b1);
        push(8'hC4, 1'b1);
        if (e >= 0) begin
            wait_cyc(e + 78);
            check("pp_level_before", int'(level), 3);
            push(8'hC5, 1'b1);
            check("pp_level_after", int'(level), 3);
        end
        drain("drain_pp");

        // 6: reset in the middle of a frame with another byte queued
        push(8'h3C, 1'b0);
        wait_fall("mid_start", e);
        push(8'h99, 1'b0);
        if (e >= 0) wait_cyc(e + 30);
        rstn = 1'b0;
        #1;
        check("mid_tx", int'(tx), 1);
        check("mid_level", int'(level), 0);
        check("mid_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_release_tx", int'(tx), 1);
        push(8'h6B, 1'b1);
        drain("drain_mid");
        repeat (20) @(negedge clk);
        check("final_tx", int'(tx), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
